shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational barrel shifter between two execute-stage issue ports (port 0 and port 1).
- Uses valid/ready handshakes on both request ports and on the response.
- Arbitrates round-robin and registers each result in a single-entry output stage, tagged with the destination tag and the winning port.
- Sits between the dual-issue dispatch logic and the writeback mux.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, at least 8.
- TAG_WIDTH, 5: destination tag width carried alongside each request.
- CNT_WIDTH, 16: width of the saturating backpressure counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_sel  in  2  op: 00 SLL, 10 SRL, 01/11 SRA
- req0_shamt  in  $clog2(DATA_WIDTH)  shift amount
- req0_data  in  DATA_WIDTH  operand
- req0_tag  in  TAG_WIDTH  destination tag
- req1_valid, req1_ready, req1_sel, req1_shamt, req1_data, req1_tag: same as port 0, for port 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_WIDTH  shifted result
- rsp_tag  out  TAG_WIDTH  tag of the result
- rsp_port  out  1  port that issued the result
- stall_cnt  out  CNT_WIDTH  cycles with rsp_valid=1 and rsp_ready=0, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_port=0, stall_cnt=0.
  - Round-robin pointer rr=0 (port 0 has priority first).
- slot_free = ~rsp_valid | rsp_ready. Pass-through ready: the output stage can accept in the same cycle it drains.
- Grant (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant rr.
  - reqN_ready = slot_free & ~flush & (grant==N) & reqN_valid.
  - At most one ready is high per cycle.
- Shifter input muxes from the granted port's sel/shamt/data. The shift is combinational in the same cycle.
- Accept (a ready high at a clock edge):
  - Next cycle: rsp_valid=1; rsp_data, rsp_tag, rsp_port loaded.
  - Latency is exactly 1 cycle.
  - rr updates to ~grant only when both requests were valid at acceptance. Otherwise rr is unchanged.
- No accept, and rsp_ready=1 with rsp_valid=1: rsp_valid clears at the next edge.
- Hold: while rsp_valid=1 and rsp_ready=0, rsp_data, rsp_tag and rsp_port are stable and no request is accepted.
- Back-to-back: with rsp_ready held at 1, one result per cycle is sustained.
- Flush:
  - At the next edge, rsp_valid=0 and stall_cnt holds its value.
  - No request is accepted in the flush cycle.
  - rr is unchanged.
- Result arithmetic:
  - SLL fills with zeros; SRL fills with zeros; SRA fills with operand MSB.
  - shamt=0 returns data unchanged.
  - Only shamt bits [$clog2(DATA_WIDTH)-1:0] are used, so there is no wrap beyond DATA_WIDTH-1.
- stall_cnt:
  - Increments on each cycle with rsp_valid & ~rsp_ready & ~flush.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Reset asserted mid-transaction: the pending result is discarded and req ready outputs drop immediately. After release, the first simultaneous request goes to port 0.

Decomposition:
- Shared execute package holds:
  - Shift op encoding constants: SH_SLL=2'b00, SH_SRL=2'b10, SH_SRA=2'b01.
  - A packed struct for the request bundle {sel, shamt, data, tag}, reused by both ports.
- One sub-module: the team's existing parametric shifter, instantiated once with size=DATA_WIDTH. Arbitration, output register and counter stay in shift_arbiter.

Test Plan:
- SLL and SRL from port 0:
  - req0 sel=00 shamt=4 data=0x0000_0001 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_tag=3, rsp_port=0.
  - sel=10 shamt=4 data=0x8000_0000 -> 0x0800_0000.
- SRA from port 1: req1 sel=01 shamt=4 data=0x8000_0000 -> rsp_data=0xF800_0000, rsp_port=1. shamt=31 data=0x8000_0000 -> 0xFFFF_FFFF. shamt=0 -> data unchanged.
- Contention: both ports valid continuously for 4 cycles, rsp_ready=1 -> grants 0,1,0,1. rsp_port sequence 0,1,0,1 with one result per cycle.
- Backpressure:
  - Result pending with rsp_ready=0 for 5 cycles -> both readies 0, rsp_* stable, stall_cnt=5.
  - Raise rsp_ready with req1 valid -> req1 accepted in that same cycle.
- Flush: pending result plus req0 valid with flush=1 for one cycle -> rsp_valid=0 next cycle, req0_ready=0 during flush, req0 accepted the following cycle.
- Reset mid-op: rst_n low asynchronously while rsp_valid=1 and rr=1 -> rsp_valid=0 immediately. After release, simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared execute-unit definitions: shift op encodings and the per-port request bundle.
// Holds no logic, so it adds no latency and has no flow control.
package shift_arbiter_pkg;

    localparam int XU_DATA_W  = 32;
    localparam int XU_TAG_W   = 5;
    localparam int XU_SHAMT_W = $clog2(XU_DATA_W);

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b01;

    typedef struct packed {
        logic [1:0]            sel;
        logic [XU_SHAMT_W-1:0] shamt;
        logic [XU_DATA_W-1:0]  data;
        logic [XU_TAG_W-1:0]   tag;
    } sh_req_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Parametric barrel shifter (SLL/SRL/SRA); purely combinational, zero latency.
// Has no handshake of its own; the caller decides when the result is captured.
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [1:0]              sel,
    input  logic [$clog2(SIZE)-1:0] shamt,
    input  logic [SIZE-1:0]         data_in,
    output logic [SIZE-1:0]         data_out
);

    always_comb begin
        data_out = '0;
        case (sel)
            SH_SLL:  data_out = data_in << shamt;
            SH_SRL:  data_out = data_in >> shamt;
            // Both 01 and 11 decode as arithmetic right shift.
            default: data_out = $unsigned($signed(data_in) >>> shamt);
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter between two issue ports; 1-cycle latency into a single-entry output stage.
// Pass-through ready: a request is taken while the stage is empty or draining; a stalled result blocks both ports.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = XU_DATA_W,
    parameter int TAG_WIDTH  = XU_TAG_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [1:0]                    req0_sel,
    input  logic [$clog2(DATA_WIDTH)-1:0] req0_shamt,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic [TAG_WIDTH-1:0]          req0_tag,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [1:0]                    req1_sel,
    input  logic [$clog2(DATA_WIDTH)-1:0] req1_shamt,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    input  logic [TAG_WIDTH-1:0]          req1_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_port,
    output logic [CNT_WIDTH-1:0]          stall_cnt
);

    sh_req_t                req0_s, req1_s, win_s;
    logic                   both_vld, grant, slot_free, accept;
    logic [DATA_WIDTH-1:0]  shift_res;

    logic                   rr_q, rr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]   rsp_tag_q, rsp_tag_d;
    logic                   rsp_port_q, rsp_port_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

    assign req0_s = '{sel: req0_sel, shamt: req0_shamt, data: req0_data, tag: req0_tag};
    assign req1_s = '{sel: req1_sel, shamt: req1_shamt, data: req1_data, tag: req1_tag};

    assign both_vld  = req0_valid & req1_valid;
    assign grant     = both_vld ? rr_q : req1_valid;
    assign slot_free = ~rsp_valid_q | rsp_ready;

    // rst_n gates the readies so they fall the moment reset asserts, not at the next edge.
    assign req0_ready = rst_n & slot_free & ~flush & ~grant & req0_valid;
    assign req1_ready = rst_n & slot_free & ~flush &  grant & req1_valid;
    assign accept     = req0_ready | req1_ready;

    assign win_s = grant ? req1_s : req0_s;

    shift_arbiter_shifter #(
        .SIZE (DATA_WIDTH)
    ) u_shifter (
        .sel      (win_s.sel),
        .shamt    (win_s.shamt),
        .data_in  (win_s.data),
        .data_out (shift_res)
    );

    always_comb begin
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_port_d  = rsp_port_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_res;
            rsp_tag_d   = win_s.tag;
            rsp_port_d  = grant;
            if (both_vld) begin
                rr_d = ~grant;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_valid_q & ~rsp_ready & ~flush & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_port_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_port_q  <= rsp_port_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_port  = rsp_port_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboarded bench for shift_arbiter: a predictor queues expected results, a monitor pops and compares them.
module tb_shift_arbiter;

    localparam int DW   = 32;
    localparam int TW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, flush;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_sel, req1_sel;
    logic [4:0]    req0_shamt, req1_shamt;
    logic [DW-1:0] req0_data, req1_data;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          rsp_valid, rsp_ready, rsp_port;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        port;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mdl_rr = 1'b0;
    int   mdl_stall = 0;

    always #5 clk = ~clk;

    shift_arbiter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_shamt (req0_shamt),
        .req0_data  (req0_data),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_shamt (req1_shamt),
        .req1_data  (req1_data),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_port   (rsp_port),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift: SLL/SRL by arithmetic, SRA by repeated sign-replicating single-bit steps.
    function automatic logic [31:0] ref_shift(input logic [1:0] sel, input logic [4:0] sh,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (sel == 2'b00) r = d << sh;
        else if (sel == 2'b10) r = d >> sh;
        else for (int i = 0; i < int'(sh); i++) r = {r[31], r[31:1]};
        return r;
    endfunction

    // Predictor: decides what the DUT must accept at the coming edge and queues the result.
    initial begin
        bit pend, g, e0, e1;
        exp_t e;
        forever begin
            @(posedge clk); #3;
            if (!rst_n) begin
                exp_q.delete();
                mdl_rr    = 1'b0;
                mdl_stall = 0;
            end else begin
                pend = (exp_q.size() != 0);
                chk("stall_cnt", 32'(stall_cnt), 32'(mdl_stall));
                if (req0_valid && req1_valid) g = mdl_rr;
                else g = req1_valid;
                e0 = !pend && !flush && req0_valid && !g;
                e1 = !pend && !flush && req1_valid && g;
                chk("req0_ready", 32'(req0_ready), 32'(e0));
                chk("req1_ready", 32'(req1_ready), 32'(e1));
                if (pend && !flush && mdl_stall < CMAX) mdl_stall++;
                if (flush) begin
                    if (pend) void'(exp_q.pop_front());
                end else if (e0 || e1) begin
                    e.port = g;
                    e.data = g ? ref_shift(req1_sel, req1_shamt, req1_data)
                               : ref_shift(req0_sel, req0_shamt, req0_data);
                    e.tag  = g ? req1_tag : req0_tag;
                    exp_q.push_back(e);
                    if (req0_valid && req1_valid) mdl_rr = !g;
                end
            end
        end
    end

    // Monitor: compares the presented result with the queue head, pops on consumer handshake.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rst_n) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                    chk("rsp_port", 32'(rsp_port), 32'(exp_q[0].port));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle();
        req0_valid = 0; req0_sel = 0; req0_shamt = 0; req0_data = 0; req0_tag = 0;
        req1_valid = 0; req1_sel = 0; req1_shamt = 0; req1_data = 0; req1_tag = 0;
    endtask

    task automatic set0(input logic [1:0] s, input logic [4:0] sh, input logic [31:0] d,
                        input logic [4:0] t);
        req0_valid = 1; req0_sel = s; req0_shamt = sh; req0_data = d; req0_tag = t;
    endtask

    task automatic set1(input logic [1:0] s, input logic [4:0] sh, input logic [31:0] d,
                        input logic [4:0] t);
        req1_valid = 1; req1_sel = s; req1_shamt = sh; req1_data = d; req1_tag = t;
    endtask

    task automatic step(input bit rdy, input bit fl);
        rsp_ready = rdy;
        flush     = fl;
        @(posedge clk); #1;
        idle();
        flush = 0;
    endtask

    initial begin
        int n;
        rst_n = 0; flush = 0; rsp_ready = 0;
        idle();
        #2;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset_rsp_port", 32'(rsp_port), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Single-port ops, including SRA sign fill and zero shift.
        set0(2'b00, 5'd4, 32'h0000_0001, 5'd3); step(1, 0);
        set0(2'b10, 5'd4, 32'h8000_0000, 5'd4); step(1, 0);
        set1(2'b01, 5'd4, 32'h8000_0000, 5'd5); step(1, 0);
        set1(2'b11, 5'd31, 32'h8000_0000, 5'd6); step(1, 0);
        set1(2'b01, 5'd0, 32'h1234_5678, 5'd7); step(1, 0);
        step(1, 0);

        // Contention: expect alternating ports, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            set0(2'b00, 5'(i), 32'hA5A5_0F0F, 5'(i));
            set1(2'b10, 5'(i + 1), 32'hF0F0_1234, 5'(8 + i));
            step(1, 0);
        end
        step(1, 0);

        // Backpressure: pending result held 5 cycles with both ports requesting.
        set0(2'b00, 5'd1, 32'h0000_0003, 5'd9); step(0, 0);
        repeat (5) begin
            set0(2'b10, 5'd2, 32'h1111_1111, 5'd1);
            set1(2'b00, 5'd2, 32'h2222_2222, 5'd2);
            step(0, 0);
        end
        chk("stall_after_5", 32'(stall_cnt), 32'd5);
        set1(2'b10, 5'd8, 32'hFF00_FF00, 5'd10); step(1, 0);
        step(1, 0);

        // Flush with a pending result and a waiting request.
        set0(2'b01, 5'd3, 32'h8000_0010, 5'd11); step(0, 0);
        set0(2'b00, 5'd2, 32'h0000_0005, 5'd12); step(0, 1);
        set0(2'b00, 5'd2, 32'h0000_0005, 5'd12); step(1, 0);
        step(1, 0);

        // Randomised traffic.
        repeat (300) begin
            if ($urandom_range(0, 9) < 6)
                set0(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 9) < 6)
                set1(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // Saturation of the stall counter.
        step(1, 0); step(1, 0);
        set0(2'b00, 5'd0, 32'h0000_CAFE, 5'd1); step(0, 0);
        repeat (20) step(0, 0);
        chk("stall_saturated", 32'(stall_cnt), 32'(CMAX));
        step(1, 0);

        // Reset mid-operation with rr pointing at port 1 and a result pending.
        n = 0;
        do begin
            set0(2'b00, 5'd1, 32'h0000_0100, 5'd20);
            set1(2'b10, 5'd1, 32'h0000_0200, 5'd21);
            step(1, 0);
            n++;
        end while (mdl_rr != 1'b1 && n < 3);
        chk("rr_is_one_before_reset", 32'(mdl_rr), 32'd1);
        set0(2'b00, 5'd2, 32'h0000_0001, 5'd22);
        set1(2'b00, 5'd3, 32'h0000_0001, 5'd23);
        rsp_ready = 1;
        rst_n = 0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_req0_ready", 32'(req0_ready), 32'd0);
        chk("midreset_req1_ready", 32'(req1_ready), 32'd0);
        chk("midreset_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        step(1, 0);
        chk("post_reset_first_port", 32'(rsp_port), 32'd0);
        set0(2'b00, 5'd2, 32'h0000_0001, 5'd22);
        set1(2'b00, 5'd3, 32'h0000_0001, 5'd23);
        step(1, 0);
        chk("post_reset_second_port", 32'(rsp_port), 32'd1);
        step(1, 0);
        step(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
